// File: rtl/alu_cmd_queue.sv
// -----------------------------------------------------------------------------
// alu_cmd_queue
//
// A command queue feeding a registered ALU output stage. The producer pushes
// {op, x, z} commands with a valid/ready handshake. The head of the queue is
// evaluated by the ALU, and the result is loaded into an output register. The
// consumer then takes each {y, err} result with a valid/ready handshake.
//
// Ports
//   clk        clock; all state changes on the rising edge
//   rst        synchronous, active-high reset; takes priority over every event
//   in_valid   producer has a command
//   in_ready   queue can accept a command (equals !full)
//   in_op      0 add, 1 sub, 2 mul (when MUL_EN), 3 invalid
//   in_x/in_z  operands, WIDTH bits each
//   out_valid  the output register holds a result
//   out_ready  consumer accepts the result
//   out_y      result, 2*WIDTH bits
//   out_err    the result came from an invalid op
//   count      number of queued entries; the output register is not counted
//   full/empty count == DEPTH / count == 0
//   reject     one-cycle pulse after the producer tried to push while full
//
// Parameters
//   WIDTH   operand width (>= 1)
//   DEPTH   queue entries (>= 2; need not be a power of two)
//   MUL_EN  1: op 2 multiplies; 0: op 2 is reported as invalid
// -----------------------------------------------------------------------------
module alu_cmd_queue #(
   parameter int WIDTH  = 8,
   parameter int DEPTH  = 4,
   parameter int MUL_EN = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [1:0]                 in_op,
   input  logic [WIDTH-1:0]           in_x,
   input  logic [WIDTH-1:0]           in_z,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [2*WIDTH-1:0]         out_y,
   output logic                       out_err,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty,
   output logic                       reject
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int EW = 2 + 2 * WIDTH;   // stored entry: {op, x, z}

   // Command storage. It has no reset: an entry is only read once the count
   // says it has been written.
   logic [EW-1:0]      mem_q [DEPTH];
   logic [DEPTH-1:0]   wr_en;

   logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]      count_q, count_d;
   logic               out_valid_q, out_valid_d;
   logic [2*WIDTH-1:0] out_y_q, out_y_d;
   logic               out_err_q, out_err_d;
   logic               reject_q, reject_d;

   logic               full_w, empty_w;
   logic               push, pop;

   logic [EW-1:0]      head;
   logic [1:0]         head_op;
   logic [2*WIDTH-1:0] x_ext, z_ext;
   logic [2*WIDTH-1:0] alu_y;
   logic               alu_err;

   // ---------------- status and handshakes ----------------
   assign full_w  = (count_q == CW'(DEPTH));
   assign empty_w = (count_q == '0);

   // A full queue never accepts, even if a pop frees a slot on the same edge.
   assign push = in_valid && !full_w;
   // Refill the output register when it is empty or is being consumed now.
   assign pop  = !empty_w && (!out_valid_q || out_ready);

   // Per-entry write enables decoded from the write pointer.
   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wr_en
      assign wr_en[gi] = push && (wr_ptr_q == PW'(gi));
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < DEPTH; i++) begin
         if (wr_en[i]) begin
            mem_q[i] <= {in_op, in_x, in_z};
         end
      end
   end

   // ---------------- ALU on the head entry ----------------
   assign head    = mem_q[rd_ptr_q];
   assign head_op = head[EW-1 -: 2];
   assign x_ext   = {{WIDTH{1'b0}}, head[2*WIDTH-1 -: WIDTH]};
   assign z_ext   = {{WIDTH{1'b0}}, head[WIDTH-1:0]};

   always_comb begin
      alu_y   = '0;
      alu_err = 1'b0;
      case (head_op)
         2'd0: alu_y = x_ext + z_ext;
         // The wrap modulo 2^(2*WIDTH) gives the two's-complement result.
         2'd1: alu_y = x_ext - z_ext;
         2'd2: begin
            if (MUL_EN != 0) begin
               // The operands are zero-extended, so the full product fits.
               alu_y = x_ext * z_ext;
            end else begin
               alu_err = 1'b1;
            end
         end
         default: alu_err = 1'b1;
      endcase
   end

   // ---------------- next-state logic ----------------
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      out_valid_d = out_valid_q;
      out_y_d     = out_y_q;
      out_err_d   = out_err_q;
      reject_d    = in_valid && full_w;

      if (push) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
      end

      if (pop) begin
         rd_ptr_d    = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
         out_valid_d = 1'b1;
         out_y_d     = alu_y;
         out_err_d   = alu_err;
      end else if (out_ready) begin
         // The result is consumed and nothing replaces it. The data is kept.
         out_valid_d = 1'b0;
      end

      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   // ---------------- state registers ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         out_valid_q <= 1'b0;
         out_y_q     <= '0;
         out_err_q   <= 1'b0;
         reject_q    <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         out_valid_q <= out_valid_d;
         out_y_q     <= out_y_d;
         out_err_q   <= out_err_d;
         reject_q    <= reject_d;
      end
   end

   // ---------------- outputs ----------------
   assign in_ready  = !full_w;
   assign full      = full_w;
   assign empty     = empty_w;
   assign count     = count_q;
   assign out_valid = out_valid_q;
   assign out_y     = out_y_q;
   assign out_err   = out_err_q;
   assign reject    = reject_q;

endmodule

// File: tb/tb_alu_cmd_queue.sv
// -----------------------------------------------------------------------------
// Testbench for alu_cmd_queue (WIDTH=8, DEPTH=4).
// Two instances share the same stimulus: dut uses MUL_EN=1 and dut_m0 uses
// MUL_EN=0. The reference model holds the queued commands in a SystemVerilog
// queue and computes results with plain integer arithmetic.
// -----------------------------------------------------------------------------
module tb_alu_cmd_queue;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int CW = $clog2(D + 1);

   typedef struct {
      logic [1:0]   op;
      logic [W-1:0] x;
      logic [W-1:0] z;
   } cmd_t;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            in_valid = 1'b0;
   logic [1:0]      in_op = '0;
   logic [W-1:0]    in_x = '0;
   logic [W-1:0]    in_z = '0;
   logic            out_ready = 1'b0;

   logic            in_ready, out_valid, out_err, full, empty, reject;
   logic [2*W-1:0]  out_y;
   logic [CW-1:0]   count;

   logic            in_ready_m0, out_valid_m0, out_err_m0, full_m0, empty_m0, reject_m0;
   logic [2*W-1:0]  out_y_m0;
   logic [CW-1:0]   count_m0;

   int checks = 0;
   int errors = 0;

   // reference model state
   cmd_t           mq[$];
   bit             mv = 0;
   logic [2*W-1:0] my1 = '0, my0 = '0;
   logic           me1 = 0, me0 = 0;
   bit             mrej = 0;

   alu_cmd_queue #(.WIDTH(W), .DEPTH(D), .MUL_EN(1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_op(in_op), .in_x(in_x), .in_z(in_z), .out_valid(out_valid),
      .out_ready(out_ready), .out_y(out_y), .out_err(out_err), .count(count),
      .full(full), .empty(empty), .reject(reject)
   );

   alu_cmd_queue #(.WIDTH(W), .DEPTH(D), .MUL_EN(0)) dut_m0 (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_m0),
      .in_op(in_op), .in_x(in_x), .in_z(in_z), .out_valid(out_valid_m0),
      .out_ready(out_ready), .out_y(out_y_m0), .out_err(out_err_m0), .count(count_m0),
      .full(full_m0), .empty(empty_m0), .reject(reject_m0)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic void alu_ref(input logic [1:0] op, input logic [W-1:0] x,
                                   input logic [W-1:0] z, input bit mul_en,
                                   output logic [2*W-1:0] y, output logic e);
      int xi = int'(x);
      int zi = int'(z);
      y = '0;
      e = 1'b0;
      case (op)
         2'd0: y = 16'(xi + zi);
         2'd1: y = 16'(xi - zi);
         2'd2: if (mul_en) y = 16'(xi * zi); else e = 1'b1;
         default: e = 1'b1;
      endcase
   endfunction

   task automatic check_all();
      chk("out_valid", 32'(out_valid), 32'(mv));
      chk("count",     32'(count),     32'(mq.size()));
      chk("full",      32'(full),      32'(mq.size() == D));
      chk("empty",     32'(empty),     32'(mq.size() == 0));
      chk("reject",    32'(reject),    32'(mrej));
      chk("out_y",     32'(out_y),     32'(my1));
      chk("out_err",   32'(out_err),   32'(me1));
      chk("m0_valid",  32'(out_valid_m0), 32'(mv));
      chk("m0_count",  32'(count_m0),  32'(mq.size()));
      chk("m0_out_y",  32'(out_y_m0),  32'(my0));
      chk("m0_err",    32'(out_err_m0), 32'(me0));
   endtask

   // One clock cycle: drive the inputs, check in_ready before the edge, and
   // advance the model at the edge. After the edge, check every output.
   task automatic step(input bit r, input bit v, input logic [1:0] op,
                       input logic [W-1:0] x, input logic [W-1:0] z, input bit rdy);
      cmd_t c;
      bit   mfull, push, pop;
      rst = r; in_valid = v; in_op = op; in_x = x; in_z = z; out_ready = rdy;
      #1;
      chk("in_ready", 32'(in_ready), 32'(mq.size() != D));
      @(posedge clk);
      if (r) begin
         mq.delete();
         mv = 0; my1 = '0; my0 = '0; me1 = 0; me0 = 0; mrej = 0;
      end else begin
         mfull = (mq.size() == D);
         mrej  = v && mfull;
         push  = v && !mfull;
         pop   = (mq.size() != 0) && (!mv || rdy);
         if (pop) begin
            c = mq.pop_front();
            alu_ref(c.op, c.x, c.z, 1'b1, my1, me1);
            alu_ref(c.op, c.x, c.z, 1'b0, my0, me0);
            mv = 1;
            $display("txn: op=%0d x=%0d z=%0d -> y=0x%04h err=%0d (m0: y=0x%04h err=%0d)",
                     c.op, c.x, c.z, my1, me1, my0, me0);
         end else if (rdy) begin
            mv = 0;
         end
         if (push) begin
            c.op = op; c.x = x; c.z = z;
            mq.push_back(c);
         end
      end
      #1;
      check_all();
   endtask

   initial begin
      // reset
      step(1, 0, 0, 0, 0, 0);
      chk("rst_valid", 32'(out_valid), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);
      chk("rst_in_ready", 32'(in_ready), 32'd1);

      // add: the result appears after the second edge
      step(0, 1, 2'd0, 8'd200, 8'd100, 1);
      chk("add_early_valid", 32'(out_valid), 32'd0);
      step(0, 0, 0, 0, 0, 1);
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_y", 32'(out_y), 32'h012C);
      chk("add_err", 32'(out_err), 32'd0);
      step(0, 0, 0, 0, 0, 1);

      // sub then mul on consecutive cycles
      step(0, 1, 2'd1, 8'd5, 8'd7, 1);
      step(0, 1, 2'd2, 8'd255, 8'd255, 1);
      chk("sub_y", 32'(out_y), 32'hFFFE);
      chk("sub_err", 32'(out_err), 32'd0);
      step(0, 0, 0, 0, 0, 1);
      chk("mul_y", 32'(out_y), 32'hFE01);
      chk("mul_err", 32'(out_err), 32'd0);
      chk("mul_m0_err", 32'(out_err_m0), 32'd1);
      step(0, 0, 0, 0, 0, 1);

      // invalid op 3, then op 2 with the multiplier disabled
      step(0, 1, 2'd3, 8'd1, 8'd1, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("inv_y", 32'(out_y), 32'd0);
      chk("inv_err", 32'(out_err), 32'd1);
      step(0, 1, 2'd2, 8'd3, 8'd4, 1);
      step(0, 0, 0, 0, 0, 1);
      chk("m0_mul_y", 32'(out_y_m0), 32'd0);
      chk("m0_mul_err", 32'(out_err_m0), 32'd1);
      chk("mul12_y", 32'(out_y), 32'd12);
      step(0, 0, 0, 0, 0, 1);

      // fill the queue while the consumer stalls; the 6th push is rejected
      for (int i = 0; i < 5; i++) step(0, 1, 2'(i % 3), 8'(10 + i), 8'(i), 0);
      chk("full_count", 32'(count), 32'd4);
      chk("full_flag", 32'(full), 32'd1);
      chk("full_in_ready", 32'(in_ready), 32'd0);
      step(0, 1, 2'd0, 8'd99, 8'd99, 0);
      chk("reject_pulse", 32'(reject), 32'd1);
      step(0, 0, 0, 0, 0, 0);
      chk("reject_clear", 32'(reject), 32'd0);
      for (int i = 0; i < 6; i++) step(0, 0, 0, 0, 0, 1);
      chk("drained_valid", 32'(out_valid), 32'd0);

      // steady state at count=2 with a push and a pop on every edge
      step(0, 1, 2'd0, 8'd1, 8'd2, 0);
      step(0, 1, 2'd0, 8'd3, 8'd4, 0);
      step(0, 1, 2'd0, 8'd5, 8'd6, 0);
      for (int i = 0; i < 10; i++) begin
         step(0, 1, 2'(i % 3), 8'(7 * i), 8'(3 + i), 1);
         chk("steady_count", 32'(count), 32'd2);
      end
      for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 0, 1);

      // reset in the middle of a stream, with a push on the same edge
      for (int i = 0; i < 4; i++) step(0, 1, 2'd0, 8'(20 + i), 8'd1, 0);
      chk("pre_rst_count", 32'(count), 32'd3);
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      step(1, 1, 2'd0, 8'd9, 8'd9, 0);
      chk("mid_rst_count", 32'(count), 32'd0);
      chk("mid_rst_valid", 32'(out_valid), 32'd0);
      chk("mid_rst_y", 32'(out_y), 32'd0);
      for (int i = 0; i < 3; i++) begin
         step(0, 0, 0, 0, 0, 1);
         chk("post_rst_valid", 32'(out_valid), 32'd0);
      end

      // randomized traffic against the model
      for (int i = 0; i < 400; i++) begin
         step(($urandom_range(0, 49) == 0), ($urandom_range(0, 3) != 0),
              2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom),
              ($urandom_range(0, 2) != 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
